// File: rtl/csr_pkg.sv
// Shared constants and helpers for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

  localparam logic [5:0] SCRATCH_PAGE = 6'b011111;

  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(
    input csr_op_e     op,
    input logic [31:0] old,
    input logic [31:0] src
  );
    logic [31:0] res;
    unique case (1'b1)
      (op == OP_SET):   res = old | src;
      (op == OP_CLEAR): res = old & ~src;
      default:          res = src;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_if.sv
// Request/response bundle between execute stage and CSR file.
interface csr_if;

  logic        csr_valid;
  logic [11:0] csr_addr;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [1:0]  csr_op;
  logic        csr_imm_sel;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_valid, csr_addr, csr_rd_en, csr_wr_en,
    output csr_op, csr_imm_sel, rs1_data, zimm,
    input  csr_rvalid, csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_addr, csr_rd_en, csr_wr_en,
    input  csr_op, csr_imm_sel, rs1_data, zimm,
    output csr_rvalid, csr_rdata, csr_illegal
  );

endinterface

// File: rtl/csr_counter.sv
// Split lo/hi counter with per-half write strobes.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value
);

  localparam int HW = CNT_W - 32;

  logic [31:0]   lo;
  logic [HW-1:0] hi;
  logic          carry;

  assign value = {hi, lo};
  assign carry = inc & (&lo);

  // A written half takes the data verbatim; carry dies on either write.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if (wr_lo)
        lo <= wdata;
      else if (inc)
        lo <= lo + 32'd1;
      if (wr_hi)
        hi <= wdata[HW-1:0];
      else if (carry && !wr_lo)
        hi <= hi + HW'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: scratch bank, cycle/instret
// counters with inhibit, and read-only user shadows.
module csr_unit
  import csr_pkg::*;
#(
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_W       = 64
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  instr_retire,
  csr_if.slave  bus
);

  logic [31:0]      scratch [NUM_SCRATCH];
  logic             inh_cy;
  logic             inh_ir;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ins;
  logic [63:0]      cyc64;
  logic [63:0]      ins64;

  logic [5:0]  idx;
  logic        scr_hit;
  logic        mapped;
  logic        ro;
  logic        illegal;
  logic        do_wr;
  logic [31:0] old;
  logic [31:0] src;
  logic [31:0] wdata;
  csr_op_e     op;

  logic cyc_wr_lo, cyc_wr_hi;
  logic ins_wr_lo, ins_wr_hi;

  assign cyc64 = 64'(cyc);
  assign ins64 = 64'(ins);
  assign op    = csr_op_e'(bus.csr_op);
  assign idx   = bus.csr_addr[5:0];

  assign scr_hit = (bus.csr_addr[11:6] == SCRATCH_PAGE)
                && ({1'b0, idx} < 7'(NUM_SCRATCH));

  always_comb begin
    old    = '0;
    mapped = 1'b0;
    if (scr_hit) begin
      mapped = 1'b1;
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (idx == 6'(i))
          old = scratch[i];
    end else begin
      unique case (bus.csr_addr)
        ADDR_MCOUNTINHIBIT: begin
          mapped = 1'b1;
          old    = {29'b0, inh_ir, 1'b0, inh_cy};
        end
        ADDR_MCYCLE, ADDR_CYCLE: begin
          mapped = 1'b1;
          old    = cyc64[31:0];
        end
        ADDR_MCYCLEH, ADDR_CYCLEH: begin
          mapped = 1'b1;
          old    = cyc64[63:32];
        end
        ADDR_MINSTRET, ADDR_INSTRET: begin
          mapped = 1'b1;
          old    = ins64[31:0];
        end
        ADDR_MINSTRETH, ADDR_INSTRETH: begin
          mapped = 1'b1;
          old    = ins64[63:32];
        end
        default: ;
      endcase
    end
  end

  assign ro  = (bus.csr_addr[11:10] == 2'b11);
  assign src = bus.csr_imm_sel ? {27'b0, bus.zimm}
                               : bus.rs1_data;

  assign illegal = bus.csr_valid
                 & (~mapped
                 | (op == OP_RSVD)
                 | (bus.csr_wr_en & ro));

  assign do_wr = bus.csr_valid & bus.csr_wr_en
               & ~illegal & ~rst;
  assign wdata = csr_apply(op, old, src);

  assign cyc_wr_lo = do_wr & (bus.csr_addr == ADDR_MCYCLE);
  assign cyc_wr_hi = do_wr & (bus.csr_addr == ADDR_MCYCLEH);
  assign ins_wr_lo = do_wr & (bus.csr_addr == ADDR_MINSTRET);
  assign ins_wr_hi = do_wr & (bus.csr_addr == ADDR_MINSTRETH);

  csr_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (~inh_cy),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (wdata),
    .value (cyc)
  );

  csr_counter #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire & ~inh_ir),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (wdata),
    .value (ins)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cy          <= 1'b0;
      inh_ir          <= 1'b0;
      bus.csr_rvalid  <= 1'b0;
      bus.csr_rdata   <= '0;
      bus.csr_illegal <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++)
        scratch[i] <= '0;
    end else begin
      if (do_wr && bus.csr_addr == ADDR_MCOUNTINHIBIT) begin
        inh_cy <= wdata[INH_CY];
        inh_ir <= wdata[INH_IR];
      end
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (do_wr && scr_hit && idx == 6'(i))
          scratch[i] <= wdata;
      bus.csr_rvalid  <= bus.csr_valid;
      bus.csr_rdata   <= (bus.csr_valid && bus.csr_rd_en
                         && !illegal) ? old : '0;
      bus.csr_illegal <= illegal;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: driver queues expected
// responses, monitor checks them one cycle later.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst;
  logic retire;

  always #5 clk = ~clk;

  csr_if bus();

  csr_unit #(.NUM_SCRATCH(4), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_retire (retire),
    .bus          (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ill;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input logic v, input logic [31:0] d,
                      input logic ill, input string nm);
    exp_t e;
    e.v   = v;
    e.d   = v ? d : 32'h0;
    e.ill = v ? ill : 1'b0;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic req(input logic [11:0] a, input logic rd,
                     input logic wr, input logic [1:0] op,
                     input logic imm, input logic [31:0] rs1,
                     input logic [4:0] z, input logic [31:0] ed,
                     input logic eill, input string nm);
    bus.csr_valid   = 1'b1;
    bus.csr_addr    = a;
    bus.csr_rd_en   = rd;
    bus.csr_wr_en   = wr;
    bus.csr_op      = op;
    bus.csr_imm_sel = imm;
    bus.rs1_data    = rs1;
    bus.zimm        = z;
    push(!rst, ed, eill, nm);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    bus.csr_valid   = 1'b0;
    bus.csr_addr    = 12'h0;
    bus.csr_rd_en   = 1'b0;
    bus.csr_wr_en   = 1'b0;
    bus.csr_op      = 2'b00;
    bus.csr_imm_sel = 1'b0;
    bus.rs1_data    = 32'h0;
    bus.zimm        = 5'h0;
    push(1'b0, 32'h0, 1'b0, nm);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a,
                    input logic [31:0] ed, input string nm);
    req(a, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 5'h0,
        ed, 1'b0, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d,
                    input logic rden, input logic [31:0] ed,
                    input string nm);
    req(a, rden, 1'b1, 2'b00, 1'b0, d, 5'h0,
        ed, 1'b0, nm);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_assert++;
        if (bus.csr_rvalid !== e.v) begin
          n_fail++;
          $display("FAIL %s rvalid: got %0b want %0b",
                   e.nm, bus.csr_rvalid, e.v);
        end
        n_assert++;
        if (bus.csr_rdata !== e.d) begin
          n_fail++;
          $display("FAIL %s rdata: got %h want %h",
                   e.nm, bus.csr_rdata, e.d);
        end
        n_assert++;
        if (bus.csr_illegal !== e.ill) begin
          n_fail++;
          $display("FAIL %s illegal: got %0b want %0b",
                   e.nm, bus.csr_illegal, e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    retire = 1'b0;
    idle("rst0");
    idle("rst1");
    req(12'h7C0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h1234, 5'h0,
        32'h0, 1'b0, "wr_in_rst");
    idle("rst2");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) idle("count_idle");
    rd(12'hB00, 32'd9,  "mcycle_c10");
    rd(12'hC00, 32'd10, "cycle_shadow");
    rd(12'hB80, 32'd0,  "mcycleh0");
    rd(12'h7C0, 32'd0,  "scr0_after_rst");
    rd(12'hB02, 32'd0,  "minstret0");

    wr(12'h7C1, 32'hDEADBEEF, 1'b1, 32'h0, "scr1_wr");
    req(12'h7C1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0, 5'h10,
        32'hDEADBEEF, 1'b0, "scr1_set");
    rd(12'h7C1, 32'hDEADBEFF, "scr1_after_set");
    wr(12'h7C2, 32'h12345678, 1'b0, 32'h0, "scr2_nord");
    rd(12'h7C2, 32'h12345678, "scr2_rd");
    req(12'h7C1, 1'b1, 1'b1, 2'b10, 1'b0, 32'hFF, 5'h0,
        32'hDEADBEFF, 1'b0, "scr1_clr");
    rd(12'h7C1, 32'hDEADBE00, "scr1_after_clr");

    wr(12'hB80, 32'h0, 1'b0, 32'h0, "mcycleh_ld");
    wr(12'hB00, 32'hFFFFFFFF, 1'b0, 32'h0, "mcycle_ld");
    rd(12'hB00, 32'hFFFFFFFF, "mcycle_max");
    rd(12'hC80, 32'd1, "carry_hi");
    rd(12'hB00, 32'd1, "carry_lo");
    wr(12'hB00, 32'h100, 1'b1, 32'd2, "lo_wr_old");
    rd(12'hB00, 32'h100, "lo_wr_exact");
    wr(12'hB00, 32'hFFFFFFFF, 1'b0, 32'h0, "lo_ld2");
    wr(12'hB80, 32'h5, 1'b0, 32'h0, "hi_wr_drop");
    rd(12'hB80, 32'h5, "hi_no_carry");
    rd(12'hC00, 32'd1, "lo_after_hi_wr");

    req(12'h320, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 5'h5,
        32'h0, 1'b0, "inh_set");
    retire = 1'b1;
    for (int i = 0; i < 3; i++) idle("ret_inh");
    retire = 1'b0;
    rd(12'hB02, 32'd0, "minstret_frozen");
    rd(12'h320, 32'h5, "inh_rd");
    wr(12'hB00, 32'h50, 1'b0, 32'h0, "mcycle_ld50");
    rd(12'hB00, 32'h50, "mcycle_frozen");
    req(12'h320, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0, 5'h5,
        32'h5, 1'b0, "inh_clr");
    retire = 1'b1;
    for (int i = 0; i < 3; i++) idle("ret_run");
    retire = 1'b0;
    rd(12'hB02, 32'd3, "minstret3");
    rd(12'hC02, 32'd3, "instret3");
    rd(12'hB00, 32'h55, "mcycle_resume");
    wr(12'h320, 32'hFFFFFFFF, 1'b0, 32'h0, "inh_all");
    rd(12'h320, 32'h5, "inh_mask");
    wr(12'h320, 32'h0, 1'b0, 32'h0, "inh_off");

    req(12'hC02, 1'b1, 1'b1, 2'b00, 1'b0, 32'h1234, 5'h0,
        32'h0, 1'b1, "ill_ro_wr");
    rd(12'hC02, 32'd3, "ro_unchanged");
    req(12'h7C1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 5'h0,
        32'h0, 1'b1, "ill_op11");
    rd(12'h7C1, 32'hDEADBE00, "op11_unchanged");
    req(12'h7C4, 1'b1, 1'b1, 2'b00, 1'b0, 32'hAAAA, 5'h0,
        32'h0, 1'b1, "ill_scr_range");
    rd(12'h7C0, 32'h0, "scr0_unchanged");
    req(12'h300, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 5'h0,
        32'h0, 1'b1, "ill_unmapped");
    rd(12'hB82, 32'h0, "minstreth0");

    idle("drain0");
    idle("drain1");
    @(posedge clk);
    #2;
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left want 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR file executing the Zicsr read/write/set/clear operations produced by the main decoder's CSR controls (read enable, write enable, write-data select, immediate select). It holds a configurable bank of scratch CSRs, 64-bit-class cycle and instret counters with inhibit control, and read-only user shadows. It sits beside the execute stage. Reads return one cycle after the request. Writes commit at the end of the request cycle.

## Interface
- NUM_SCRATCH, 4: number of custom R/W scratch CSRs at 0x7C0..0x7C0+NUM_SCRATCH-1; range 1..64.
- CNT_W, 64: counter width; range 33..64; high halves are CNT_W-32 bits, zero-extended on read.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- csr_valid  in  1  CSR instruction present this cycle
- csr_addr  in  12  CSR address
- csr_rd_en  in  1  read requested (decoder CSR_reg_rd)
- csr_wr_en  in  1  write requested (decoder CSR_reg_wr)
- csr_op  in  2  00 write, 01 set, 10 clear, 11 reserved (illegal)
- csr_imm_sel  in  1  1: source = zero-extended zimm; 0: rs1_data
- rs1_data  in  32  register source
- zimm  in  5  immediate source
- instr_retire  in  1  one instruction retired this cycle
- csr_rvalid  out  1  csr_rdata/csr_illegal valid (1 cycle after csr_valid)
- csr_rdata  out  32  old CSR value
- csr_illegal  out  1  access fault for the request

## Operation
- Map: 0x7C0+i scratch[i]; 0x320 mcountinhibit (bit0 CY, bit2 IR writable, others read 0); 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; 0xC00/0xC80/0xC02/0xC82 read-only shadows of the same counters.
- src = csr_imm_sel ? {27'b0,zimm} : rs1_data. New value: write src; set old|src; clear old&~src.
- Illegal when csr_valid and any of: unmapped address; csr_op=11; csr_wr_en=1 on 0xC-range. Illegal request: no state change; rdata 0.
- csr_rd_en=0: rdata returns 0 (no read side effect exists, so this only affects the output). csr_wr_en=0: no write.
- mcycle increments every cycle unless CY inhibited; minstret increments on instr_retire unless IR inhibited. Both wrap from 2^CNT_W-1 to 0.
- Write to a counter half in the same cycle as an increment: written half takes the new value exactly, with no increment applied. Writing lo suppresses that cycle's carry into hi. Writing hi leaves lo incrementing normally and drops any carry out of lo.
- Write to mcountinhibit takes effect from the next cycle; the increment in the write cycle uses the old inhibit.
- Hi-half writes truncate src to CNT_W-32 bits.

## Timing
- Request sampled at edge k; csr_rvalid=1, csr_rdata=pre-write value at edge k+1. Fully pipelined: one request per cycle, no stall.
- Back-to-back to same CSR: second read observes first's write.
- Counter reads return the value before this cycle's increment.
- Reset: all scratch, counters, mcountinhibit, csr_rdata, csr_rvalid, csr_illegal = 0. A request in a cycle with rst=1 is dropped (no write, rvalid 0 next cycle). Reset overrides simultaneous writes and increments.
- csr_valid=0: csr_rvalid=0 next cycle; csr_rdata and csr_illegal are forced to 0.

## Structure
- csr_pkg: CSR address constants, csr_op encoding, mcountinhibit bit indices.
- Sub-module csr_counter (CNT_W): increment enable, lo/hi write strobes, write data, value out. Instantiate twice (cycle, instret).
- Scratch bank as an array indexed by csr_addr[5:0] when csr_addr[11:6]=6'b011111 and index<NUM_SCRATCH.

## Test plan
- Write 0xDEADBEEF to 0x7C1, then set via zimm=5'h10 -> second rdata 0xDEADBEEF, subsequent read 0xDEADBEFF.
- Reset release, read 0xB00 at cycle 10 -> rdata 9 (counts from first post-reset edge); 0xC00 same cycle value matches.
- Load mcycle lo 0xFFFFFFFF, hi 0 -> two cycles later hi=1, lo=1; write lo coinciding with an increment -> lo equals exactly the written value.
- Set mcountinhibit=0x5, pulse instr_retire 3 times -> minstret unchanged; clear inhibit, 3 retires -> +3.
- Write to 0xC02, csr_op=11, and address 0x7C0+NUM_SCRATCH -> csr_illegal=1, rdata 0, no state change.
- Assert rst with csr_valid, csr_wr_en on 0x7C0 -> scratch stays 0, csr_rvalid 0 next cycle.
